// File: rtl/valu_seq.sv
// Element sequencer for the vector ALU path: steps the shared scalar ALU through each element
// of one vector op, driving VRF read/write addresses and ALU control, stalling for multi-cycle MUL.
module valu_seq #(
  parameter int unsigned VLMAX   = 16,
  parameter int unsigned ELEM_W  = $clog2(VLMAX),
  parameter int unsigned VL_W    = $clog2(VLMAX) + 1,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [2:0]        ctrl_i,
  input  logic [4:0]        vs1_i,
  input  logic [4:0]        vs2_i,
  input  logic [4:0]        vd_i,
  input  logic [VL_W-1:0]   vl_i,
  output logic [4:0]        rd_vreg1_o,
  output logic [4:0]        rd_vreg2_o,
  output logic [ELEM_W-1:0] rd_elem_o,
  output logic [2:0]        alu_ctrl_o,
  output logic              wr_en_o,
  output logic [4:0]        wr_vreg_o,
  output logic [ELEM_W-1:0] wr_elem_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned   LatW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [VL_W-1:0] VlMax = VL_W'(VLMAX);
  localparam logic [LatW-1:0] LatLast = LatW'(MUL_LAT - 1);
  localparam logic [2:0]    CtrlAdd = 3'b001;
  localparam logic [2:0]    CtrlMul = 3'b110;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [4:0]          vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [VL_W-1:0]     vl_q, vl_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [LatW-1:0]     lat_q, lat_d;

  logic [2:0]          ctrl_legal;
  logic [VL_W-1:0]     vl_eff;
  logic                step;
  logic                last_elem;

  // Unsupported codes fall back to add so the shared ALU always sees a defined op.
  always_comb begin
    ctrl_legal = CtrlAdd;
    case (ctrl_i)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b110: ctrl_legal = ctrl_i;
      default:                                ctrl_legal = CtrlAdd;
    endcase
  end

  assign vl_eff    = (vl_i > VlMax) ? VlMax : vl_i;
  assign step      = (ctrl_q != CtrlMul) || (lat_q == LatLast);
  assign last_elem = (VL_W'(elem_q) == (vl_q - VL_W'(1)));

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    vl_d    = vl_q;
    elem_d  = elem_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid_i) begin
          ctrl_d  = ctrl_legal;
          vs1_d   = vs1_i;
          vs2_d   = vs2_i;
          vd_d    = vd_i;
          vl_d    = vl_eff;
          elem_d  = '0;
          lat_d   = '0;
          state_d = (vl_eff == '0) ? StDone : StExec;
        end
      end
      StExec: begin
        if (step) begin
          lat_d = '0;
          if (last_elem) begin
            state_d = StDone;
          end else begin
            elem_d = elem_q + ELEM_W'(1);
          end
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      vl_q    <= '0;
      elem_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      vl_q    <= vl_d;
      elem_q  <= elem_d;
      lat_q   <= lat_d;
    end
  end

  // Addresses and control are only driven while stepping elements; zero otherwise.
  always_comb begin
    rd_vreg1_o = '0;
    rd_vreg2_o = '0;
    rd_elem_o  = '0;
    alu_ctrl_o = '0;
    wr_en_o    = 1'b0;
    wr_vreg_o  = '0;
    wr_elem_o  = '0;
    if (state_q == StExec) begin
      rd_vreg1_o = vs1_q;
      rd_vreg2_o = vs2_q;
      rd_elem_o  = elem_q;
      alu_ctrl_o = ctrl_q;
      wr_en_o    = step;
      wr_vreg_o  = vd_q;
      wr_elem_o  = elem_q;
    end
  end

  assign start_ready_o = (state_q == StIdle);
  assign busy_o        = !start_ready_o;
  assign done_o        = (state_q == StDone);

endmodule
